mem_store_buffer: RTL and testbench

//  Posted-write buffer between the MEM-stage load/store controls and DATA_MEMORY.
//  - Stores are queued in a FIFO and drained to memory when the port has no load
//    to serve.
//  - Loads always win the single memory port and get forwarding from the buffer.
//  - The pipeline stalls only when a store arrives while the FIFO is full and

---
 rtl/mem_store_buffer.sv | 106 ++++++++++
 tb/tb_mem_store_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the MEM stage and DATA_MEMORY.
// Loads own the single memory port; queued stores drain whenever it is free.
module mem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_mem_read,
    input  logic                     cpu_mem_write,
    input  logic [ADDR_W-1:0]        cpu_address,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     stall,
    output logic                     dm_mem_read,
    output logic                     dm_mem_write,
    output logic [ADDR_W-1:0]        dm_address,
    output logic [DATA_W-1:0]        dm_write_val,
    input  logic [DATA_W-1:0]        dm_out,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           entries [DEPTH];
    logic [DEPTH-1:0] valid;
    ptr_t             head;
    ptr_t             tail;
    logic [CNT_W-1:0] cnt;

    logic             drain;
    logic             enq;
    logic             fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Port arbitration: a pending load always takes the memory port.
    always_comb begin
        empty        = (cnt == '0);
        drain        = !empty && !cpu_mem_read;
        stall        = cpu_mem_write && (cnt == CNT_W'(DEPTH)) && !drain;
        enq          = cpu_mem_write && !stall;
        dm_mem_read  = cpu_mem_read;
        dm_mem_write = drain;
        dm_address   = cpu_mem_read ? cpu_address : entries[head].addr;
        dm_write_val = entries[head].data;
        count        = cnt;
    end

    // Forwarding walks oldest to youngest so the newest matching store wins.
    always_comb begin
        ptr_t idx;
        idx      = head;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (entries[idx].addr == cpu_address)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx].data;
            end
        end
        cpu_rdata = fwd_hit ? fwd_data : dm_out;
    end

    // Pointer, occupancy and valid tracking; enqueue overrides drain on a shared slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            valid <= '0;
        end else begin
            if (drain) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            case ({enq, drain})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= '{addr: cpu_address, data: cpu_wdata};
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a fixed-content memory model and a write log.
module tb_mem_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_address;
    logic [31:0] dm_write_val;
    logic [31:0] dm_out;
    logic        empty;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    int base;
    logic [63:0] wlog [$];

    always #5 clk = ~clk;

    mem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .stall(stall), .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
        .dm_address(dm_address), .dm_write_val(dm_write_val), .dm_out(dm_out),
        .empty(empty), .count(count)
    );

    // Read-side memory contents: only the preloaded words matter to loads.
    assign dm_out = (dm_address == 32'd1001) ? 32'd4 :
                    (dm_address == 32'd902)  ? 32'd1 : 32'd0;

    always @(posedge clk) begin
        if (dm_mem_write) wlog.push_back({dm_address, dm_write_val});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        cpu_mem_read  = r;
        cpu_mem_write = w;
        cpu_address   = a;
        cpu_wdata     = d;
        @(negedge clk);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 20 && !empty; i++) op(1'b0, 1'b0, 32'd0, 32'd0);
        check(tag, 64'(empty), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
        cpu_address = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_dmwr",  64'(dm_mem_write), 64'd0);
        rst = 1'b0;

        // Reset asserted while three stores are queued and one is draining
        base = wlog.size();
        for (int i = 0; i < 3; i++) op(1'b1, 1'b1, 32'd3000 + 32'(i), 32'd11 + 32'(i));
        op(1'b0, 1'b0, 32'd0, 32'd0);
        check("t1_count3", 64'(count), 64'd3);
        check("t1_drain",  64'(dm_mem_write), 64'd1);
        check("t1_addr",   64'(dm_address), 64'd3000);
        rst = 1'b1;
        #1;
        check("t1_rcount", 64'(count), 64'd0);
        check("t1_rempty", 64'(empty), 64'd1);
        check("t1_rdmwr",  64'(dm_mem_write), 64'd0);
        op(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        op(1'b0, 1'b0, 32'd0, 32'd0);
        op(1'b0, 1'b0, 32'd0, 32'd0);
        check("t1_nowrite", 64'(wlog.size()), 64'(base));

        // Single store drains on the next idle cycle
        base = wlog.size();
        op(1'b0, 1'b1, 32'd900, 32'd7);
        check("t2_stall", 64'(stall), 64'd0);
        op(1'b0, 1'b0, 32'd0, 32'd0);
        check("t2_dmwr",  64'(dm_mem_write), 64'd1);
        check("t2_addr",  64'(dm_address), 64'd900);
        check("t2_wval",  64'(dm_write_val), 64'd7);
        op(1'b0, 1'b0, 32'd0, 32'd0);
        check("t2_empty", 64'(empty), 64'd1);
        check("t2_nlog",  64'(wlog.size()), 64'(base + 1));
        if (wlog.size() > base) check("t2_mem", wlog[base], {32'd900, 32'd7});

        // Forwarding: newest duplicate wins, same-cycle store is not visible
        base = wlog.size();
        op(1'b1, 1'b1, 32'd1000, 32'd5);
        check("t3_rd_first", 64'(cpu_rdata), 64'd0);
        op(1'b1, 1'b1, 32'd1000, 32'd9);
        check("t3_rd_old",   64'(cpu_rdata), 64'd5);
        op(1'b1, 1'b0, 32'd1000, 32'd0);
        check("t3_rd_fwd",   64'(cpu_rdata), 64'd9);
        check("t3_count",    64'(count), 64'd2);
        op(1'b1, 1'b0, 32'd1001, 32'd0);
        check("t3_rd_mem",   64'(cpu_rdata), 64'd4);
        wait_empty("t3_empty");
        check("t3_nlog", 64'(wlog.size()), 64'(base + 2));
        if (wlog.size() >= base + 2) begin
            check("t3_mem0", wlog[base],     {32'd1000, 32'd5});
            check("t3_mem1", wlog[base + 1], {32'd1000, 32'd9});
        end

        // Full FIFO with a load pending stalls the fifth store
        base = wlog.size();
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 1'b1, 32'd4000 + 32'(i), 32'd40 + 32'(i));
            check("t4_fill_stall", 64'(stall), 64'd0);
        end
        op(1'b1, 1'b1, 32'd4004, 32'd44);
        check("t4_stall_a", 64'(stall), 64'd1);
        check("t4_count_a", 64'(count), 64'd4);
        op(1'b1, 1'b1, 32'd4004, 32'd44);
        check("t4_stall_b", 64'(stall), 64'd1);
        check("t4_count_b", 64'(count), 64'd4);
        op(1'b0, 1'b1, 32'd4004, 32'd44);
        check("t4_nostall", 64'(stall), 64'd0);
        check("t4_dmaddr",  64'(dm_address), 64'd4000);
        op(1'b0, 1'b0, 32'd0, 32'd0);
        check("t4_count_c", 64'(count), 64'd4);
        wait_empty("t4_empty");
        check("t4_nlog", 64'(wlog.size()), 64'(base + 5));
        if (wlog.size() >= base + 5)
            for (int i = 0; i < 5; i++)
                check("t4_order", wlog[base + i], {32'd4000 + 32'(i), 32'd40 + 32'(i)});

        // Back-to-back stores with no loads: never stall, pointers wrap
        base = wlog.size();
        for (int i = 0; i < 10; i++) begin
            op(1'b0, 1'b1, 32'd2000 + 32'(i), 32'd200 + 32'(i));
            check("t5_stall", 64'(stall), 64'd0);
        end
        wait_empty("t5_empty");
        check("t5_nlog", 64'(wlog.size()), 64'(base + 10));
        if (wlog.size() >= base + 10)
            for (int i = 0; i < 10; i++)
                check("t5_order", wlog[base + i], {32'd2000 + 32'(i), 32'd200 + 32'(i)});

        // A load pauses the drain for one cycle
        base = wlog.size();
        op(1'b0, 1'b1, 32'd5000, 32'd55);
        op(1'b1, 1'b0, 32'd902, 32'd0);
        check("t6_addr",  64'(dm_address), 64'd902);
        check("t6_dmwr",  64'(dm_mem_write), 64'd0);
        check("t6_dmrd",  64'(dm_mem_read), 64'd1);
        check("t6_rdata", 64'(cpu_rdata), 64'd1);
        op(1'b0, 1'b0, 32'd0, 32'd0);
        check("t6_count", 64'(count), 64'd1);
        check("t6_daddr", 64'(dm_address), 64'd5000);
        wait_empty("t6_empty");
        check("t6_nlog", 64'(wlog.size()), 64'(base + 1));
        if (wlog.size() > base) check("t6_mem", wlog[base], {32'd5000, 32'd55});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
